id_ex_stage: RTL

Pipeline register between the decode stage and the execute stage of the RISC-V core. It captures one decoded instruction per cycle: register operands, the extended immediate, the PC, the destination register, and the control bundle, including the 3-bit ALUControl from the ALU decoder. It presents that instruction to the ALU under a valid/ready handshake. A two-entry skid buffer sustains full throughput under back-pressure, a flush port squashes in-flight instructions on taken branches, and a saturating counter records execute-side stall cycles.

---
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode/execute pipeline register with two-entry skid buffer
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rd1,
    input  logic [XLEN-1:0]  in_rd2,
    input  logic [XLEN-1:0]  in_imm_ext,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_alu_control,
    input  logic             in_alu_src,
    input  logic             in_reg_write,
    input  logic             in_mem_write,
    input  logic             in_branch,
    input  logic             in_jump,
    input  logic [1:0]       in_result_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rd1,
    output logic [XLEN-1:0]  out_rd2,
    output logic [XLEN-1:0]  out_imm_ext,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_alu_control,
    output logic             out_alu_src,
    output logic             out_reg_write,
    output logic             out_mem_write,
    output logic             out_branch,
    output logic             out_jump,
    output logic [1:0]       out_result_src,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
    } payload_t;

    payload_t        in_pkt;
    payload_t        main_q, main_d;
    payload_t        skid_q, skid_d;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic            in_fire;
    logic            out_fire;

    // Gather the decode-side fields into one payload word
    always_comb begin
        in_pkt = '{
            rd1:         in_rd1,
            rd2:         in_rd2,
            imm_ext:     in_imm_ext,
            pc:          in_pc,
            rd:          in_rd,
            alu_control: in_alu_control,
            alu_src:     in_alu_src,
            reg_write:   in_reg_write,
            mem_write:   in_mem_write,
            branch:      in_branch,
            jump:        in_jump,
            result_src:  in_result_src
        };
    end

    // in_ready depends only on the registered skid state, never on out_ready
    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_q & out_ready;

    // Main/skid load, drain and squash decisions
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Squashed entries must not leave side-effecting control bits behind
            main_valid_d     = 1'b0;
            skid_valid_d     = 1'b0;
            main_d.reg_write = 1'b0;
            main_d.mem_write = 1'b0;
            main_d.branch    = 1'b0;
            main_d.jump      = 1'b0;
            skid_d.reg_write = 1'b0;
            skid_d.mem_write = 1'b0;
            skid_d.branch    = 1'b0;
            skid_d.jump      = 1'b0;
        end else if (!main_valid_q) begin
            if (in_fire) begin
                main_d       = in_pkt;
                main_valid_d = 1'b1;
            end
        end else if (out_fire) begin
            if (skid_valid_q) begin
                // Skid holds the older instruction; in_ready is low so no input arrives
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d = in_pkt;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_pkt;
            skid_valid_d = 1'b1;
        end
    end

    // Saturating count of cycles the execute stage refuses a valid instruction
    always_comb begin
        stall_d = stall_q;
        if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State registers; reset clears both entries and the whole payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_q      <= stall_d;
        end
    end

    assign out_rd1         = main_q.rd1;
    assign out_rd2         = main_q.rd2;
    assign out_imm_ext     = main_q.imm_ext;
    assign out_pc          = main_q.pc;
    assign out_rd          = main_q.rd;
    assign out_alu_control = main_q.alu_control;
    assign out_alu_src     = main_q.alu_src;
    assign out_reg_write   = main_q.reg_write;
    assign out_mem_write   = main_q.mem_write;
    assign out_branch      = main_q.branch;
    assign out_jump        = main_q.jump;
    assign out_result_src  = main_q.result_src;
    assign stall_count     = stall_q;

endmodule
